gate_dir_sensor: RTL and testbench

- Front end that drives the occupancy counter's active-low up/down request inputs.
- Reads two raw active-low beam sensors (A outer, B inner) at a single-lane gate and debounces them.
- Decodes the direction of a complete pass-through: entry issues one up request, exit issues one down request.
- Aborted, reversed or illegal sequences issue no request; entries while the counter is full are rejected and flagged.

---
 rtl/gate_pkg.sv | 25 ++
 rtl/sensor_debounce.sv | 49 ++++
 rtl/gate_dir_sensor.sv | 181 ++++++++++++++++++
 tb/tb_gate_dir_sensor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate direction sensor.
//   - FSM state encoding for the pass-through decoder (3 bits, 8 states)
//   - synchronizer depth and timeout counter width
//   - active-low request levels used on the up/down outputs
package gate_pkg;

   localparam int SYNC_STAGES = 2;
   localparam int TMO_W       = 8;

   // The occupancy counter's request inputs are active-low.
   localparam logic REQ_ON  = 1'b0;
   localparam logic REQ_OFF = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      IN_A   = 3'd1,
      IN_AB  = 3'd2,
      IN_B   = 3'd3,
      OUT_B  = 3'd4,
      OUT_BA = 3'd5,
      OUT_A  = 3'd6,
      ABORT  = 3'd7
   } state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Synchronizer and debouncer for one raw active-low beam sensor.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high
//   raw    - raw beam level, asynchronous to clk (0 = blocked)
//   level  - debounced beam level (0 = blocked), resets to 1 (clear)
// The debounced level only follows the synchronized sample after
// DEB_CYCLES consecutive samples that disagree with the current level;
// any sample that agrees with the current level restarts the count.
module sensor_debounce
   import gate_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   logic [SYNC_STAGES-1:0] sync;
   logic [3:0]             cnt;
   logic                   samp;

   assign samp = sync[SYNC_STAGES-1];

   // NOTE: the synchronizer resets to the "clear" level so that a sensor
   // is never seen as blocked merely because reset was released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync  <= '1;
         cnt   <= '0;
         level <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments keep every register here sampling
         // the pre-edge values, so shift and counter update stay in step.
         sync <= {sync[SYNC_STAGES-2:0], raw};
         if (samp == level) begin
            cnt <= '0;
         end else if (cnt == 4'(DEB_CYCLES - 1)) begin
            level <= samp;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/gate_dir_sensor.sv
// Direction decoder for a single-lane gate with two beams (A outer,
// B inner). Drives the occupancy counter's active-low request inputs.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high
//   sens_a     - raw outer beam, active-low, asynchronous
//   sens_b     - raw inner beam, active-low, asynchronous
//   led_full   - counter full flag, active-high
//   led_empty  - counter empty flag, active-high
//   up         - entry request, active-low one-cycle pulse
//   down       - exit request, active-low one-cycle pulse
//   err        - one-cycle pulse on abort (timeout or illegal transition)
//   reject     - one-cycle pulse when a completed pass is suppressed
//   busy       - high while the decoder is not idle
module gate_dir_sensor
   import gate_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int TMO_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic sens_a,
   input  logic sens_b,
   input  logic led_full,
   input  logic led_empty,
   output logic up,
   output logic down,
   output logic err,
   output logic reject,
   output logic busy
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

   logic             lvl_a;
   logic             lvl_b;
   logic [1:0]       ab;
   state_t           state;
   state_t           nxt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             illegal;
   logic             timed_out;
   logic             entry_done;
   logic             exit_done;

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
      .clk   (clk),
      .reset (reset),
      .raw   (sens_a),
      .level (lvl_a)
   );

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
      .clk   (clk),
      .reset (reset),
      .raw   (sens_b),
      .level (lvl_b)
   );

   // {a, b}: 1 means the beam is blocked.
   assign ab = {~lvl_a, ~lvl_b};

   // Transition table. Pairs not listed for a state hold the state;
   // pairs that skip a step of the sequence abort.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement can infer a latch.
      nxt        = state;
      illegal    = 1'b0;
      timed_out  = 1'b0;
      entry_done = 1'b0;
      exit_done  = 1'b0;

      case (state)
         IDLE: begin
            case (ab)
               2'b10:   nxt = IN_A;
               2'b01:   nxt = OUT_B;
               2'b11:   illegal = 1'b1;
               default: ;
            endcase
         end
         IN_A: begin
            case (ab)
               2'b11:   nxt = IN_AB;
               2'b00:   nxt = IDLE;        // backed out
               2'b01:   illegal = 1'b1;
               default: ;
            endcase
         end
         IN_AB: begin
            case (ab)
               2'b01:   nxt = IN_B;
               2'b10:   nxt = IN_A;
               2'b00:   illegal = 1'b1;
               default: ;
            endcase
         end
         IN_B: begin
            case (ab)
               2'b00: begin
                  nxt        = IDLE;
                  entry_done = 1'b1;
               end
               2'b11:   nxt = IN_AB;
               2'b10:   illegal = 1'b1;
               default: ;
            endcase
         end
         OUT_B: begin
            case (ab)
               2'b11:   nxt = OUT_BA;
               2'b00:   nxt = IDLE;        // backed out
               2'b10:   illegal = 1'b1;
               default: ;
            endcase
         end
         OUT_BA: begin
            case (ab)
               2'b10:   nxt = OUT_A;
               2'b01:   nxt = OUT_B;
               2'b00:   illegal = 1'b1;
               default: ;
            endcase
         end
         OUT_A: begin
            case (ab)
               2'b00: begin
                  nxt       = IDLE;
                  exit_done = 1'b1;
               end
               2'b11:   nxt = OUT_BA;
               2'b01:   illegal = 1'b1;
               default: ;
            endcase
         end
         ABORT: begin
            if (ab == 2'b00) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase

      if (illegal) nxt = ABORT;

      // A legal move in the same cycle as the deadline wins over the timeout.
      if (nxt == state && state != IDLE && state != ABORT && tmo_cnt == TMO_LAST) begin
         nxt       = ABORT;
         timed_out = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         tmo_cnt <= '0;
         up      <= REQ_OFF;
         down    <= REQ_OFF;
         err     <= 1'b0;
         reject  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state <= nxt;

         // Clears on any state change; only runs inside a pass sequence.
         if (nxt != state || state == IDLE || state == ABORT)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + 1'b1;

         // Outputs are registered from the decision so they appear together
         // with the new state; flags are sampled in the deciding cycle.
         busy   <= (nxt != IDLE);
         err    <= illegal | timed_out;
         up     <= (entry_done && !led_full)  ? REQ_ON : REQ_OFF;
         down   <= (exit_done  && !led_empty) ? REQ_ON : REQ_OFF;
         reject <= (entry_done && led_full) || (exit_done && led_empty);
      end
   end

endmodule

// File: tb/tb_gate_dir_sensor.sv
// Scoreboard bench for gate_dir_sensor. Stimulus pushes each expected
// output pulse (kind + clock cycle) into a queue; a monitor sampling on the
// falling edge pops and compares every pulse the DUT presents.
module tb_gate_dir_sensor;

   typedef enum int {EV_UP, EV_DOWN, EV_ERR, EV_REJ} ev_t;
   typedef struct {
      ev_t kind;
      int  cyc;
   } exp_t;

   // Raw edge -> debounced level (2 + 4) -> FSM/output register (+1).
   localparam int LAT = 7;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sens_a = 1'b1;
   logic sens_b = 1'b1;
   logic led_full = 1'b0;
   logic led_empty = 1'b0;
   logic up, down, err, reject, busy;

   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   busy_rises = 0;
   logic busy_q = 1'b0;
   exp_t sb[$];

   gate_dir_sensor #(.DEB_CYCLES(4), .TMO_CYCLES(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .sens_a    (sens_a),
      .sens_b    (sens_b),
      .led_full  (led_full),
      .led_empty (led_empty),
      .up        (up),
      .down      (down),
      .err       (err),
      .reject    (reject),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic act, input logic req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic observe(input ev_t k);
      exp_t e;
      compared++;
      if (sb.size() == 0) begin
         mismatched++;
         $display("FAIL unexpected_pulse: got %s at cycle %0d, expected none", k.name(), cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != k || e.cyc != cyc) begin
            mismatched++;
            $display("FAIL pulse: got %s at cycle %0d expected %s at cycle %0d",
                     k.name(), cyc, e.kind.name(), e.cyc);
         end
      end
   endtask

   // Monitor: every pulse on any output is matched against the queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (up == 1'b0)   observe(EV_UP);
         if (down == 1'b0) observe(EV_DOWN);
         if (err)          observe(EV_ERR);
         if (reject)       observe(EV_REJ);
         if (up == 1'b0 && down == 1'b0) begin
            compared++;
            mismatched++;
            $display("FAIL up_down_both_low: got up=0 down=0 expected not both low (cycle %0d)", cyc);
         end
         if (busy && !busy_q) busy_rises++;
      end
      busy_q = busy;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic a, input logic b, input int hold);
      sens_a = a;
      sens_b = b;
      step(hold);
   endtask

   task automatic expect_at(input ev_t k, input int at);
      exp_t e;
      e.kind = k;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   // Every expected pulse of a phase must have been consumed by its end.
   task automatic drain(input string name);
      step(15);
      check_int({name, "_pending"}, sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      // Watchdog: the run is far shorter than this.
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      // Reset state.
      step(2);
      check("reset_up", up, 1'b1);
      check("reset_down", down, 1'b1);
      check("reset_err", err, 1'b0);
      check("reset_reject", reject, 1'b0);
      check("reset_busy", busy, 1'b0);
      reset = 1'b0;
      step(5);

      // Entry with room: A, AB, B, clear -> one up pulse.
      led_full = 1'b0;
      drive(1'b0, 1'b1, 20);
      check("entry_busy", busy, 1'b1);
      drive(1'b0, 1'b0, 20);
      drive(1'b1, 1'b0, 20);
      expect_at(EV_UP, cyc + LAT);
      drive(1'b1, 1'b1, 20);
      drain("entry");
      check("entry_idle", busy, 1'b0);

      // Entry while full -> reject, no up.
      led_full = 1'b1;
      drive(1'b0, 1'b1, 20);
      drive(1'b0, 1'b0, 20);
      drive(1'b1, 1'b0, 20);
      expect_at(EV_REJ, cyc + LAT);
      drive(1'b1, 1'b1, 20);
      drain("entry_full");
      led_full = 1'b0;

      // Exit while empty -> reject, no down.
      led_empty = 1'b1;
      drive(1'b1, 1'b0, 20);
      drive(1'b0, 1'b0, 20);
      drive(1'b0, 1'b1, 20);
      expect_at(EV_REJ, cyc + LAT);
      drive(1'b1, 1'b1, 20);
      drain("exit_empty");

      // Exit with occupants -> one down pulse.
      led_empty = 1'b0;
      drive(1'b1, 1'b0, 20);
      drive(1'b0, 1'b0, 20);
      drive(1'b0, 1'b1, 20);
      expect_at(EV_DOWN, cyc + LAT);
      drive(1'b1, 1'b1, 20);
      drain("exit");

      // Back-out: A then release -> no pulse at all.
      drive(1'b0, 1'b1, 20);
      drive(1'b1, 1'b1, 20);
      drain("backout");

      // Bounce on A, then settle blocked: IN_A entered exactly once.
      begin
         int rises0;
         rises0 = busy_rises;
         for (int i = 0; i < 10; i++) drive(i[0], 1'b1, 1);
         drive(1'b0, 1'b1, 20);
         drive(1'b1, 1'b1, 20);
         drain("bounce");
         check_int("bounce_busy_rises", busy_rises - rises0, 1);
      end

      // Timeout: A held 100 cycles -> single err 64 cycles after IN_A entry.
      expect_at(EV_ERR, cyc + LAT + 64);
      drive(1'b0, 1'b1, 100);
      check("timeout_abort_busy", busy, 1'b1);
      drive(1'b1, 1'b1, 20);
      drain("timeout");
      check("timeout_idle", busy, 1'b0);

      // Both beams blocked together from IDLE -> illegal, err pulse.
      expect_at(EV_ERR, cyc + LAT);
      drive(1'b0, 1'b0, 20);
      drive(1'b1, 1'b1, 20);
      drain("illegal");

      // Reset in IN_B: outputs return to reset values at once, and the
      // later release of B completes no pass.
      drive(1'b0, 1'b1, 20);
      drive(1'b0, 1'b0, 20);
      drive(1'b1, 1'b0, 20);
      check("pre_reset_busy", busy, 1'b1);
      reset = 1'b1;
      #1;
      check("midreset_up", up, 1'b1);
      check("midreset_busy", busy, 1'b0);
      step(1);
      reset = 1'b0;
      step(20);
      drive(1'b1, 1'b1, 20);
      drain("midreset");
      check("midreset_idle", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
